// File: rtl/db9_pkg.sv
// db9_pkg: shared scanner state enum, DB9 pin indices and default timing.
// Also provides the TH level that belongs to each scan state.
package db9_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PH0,
    ST_PH1,
    ST_PH2,
    ST_PH3,
    ST_PH4,
    ST_PH5,
    ST_PH6,
    ST_PH7
  } db9_state_e;

  localparam int DB9_D0 = 0;
  localparam int DB9_D1 = 1;
  localparam int DB9_D2 = 2;
  localparam int DB9_D3 = 3;
  localparam int DB9_D4 = 4;
  localparam int DB9_D5 = 5;

  localparam int DB9_SETTLE_DEF = 12;
  localparam int DB9_IDLE_DEF   = 2000;

  // Odd phases pull TH low; idle and even phases hold it high.
  function automatic logic th_level(
    db9_state_e s
  );
    return !(s inside {ST_PH1, ST_PH3,
                       ST_PH5, ST_PH7});
  endfunction

endpackage

// File: rtl/db9_pad_scan_if.sv
// db9_pad_scan_if: pad pins plus decoded button bundle of one DB9 port.
// master = scanner (drives TH, buttons, PRESENT, SIX_BTN); slave = pad/host.
interface db9_pad_scan_if;

  logic [5:0] DB9_IN;
  logic       DB9_TH;
  logic       P_UP;
  logic       P_DOWN;
  logic       P_LEFT;
  logic       P_RIGHT;
  logic       P_A;
  logic       P_B;
  logic       P_C;
  logic       P_START;
  logic       P_MODE;
  logic       P_X;
  logic       P_Y;
  logic       P_Z;
  logic       PRESENT;
  logic       SIX_BTN;

  modport master (
    input  DB9_IN,
    output DB9_TH,
    output P_UP, P_DOWN, P_LEFT, P_RIGHT,
    output P_A, P_B, P_C, P_START,
    output P_MODE, P_X, P_Y, P_Z,
    output PRESENT, SIX_BTN
  );

  modport slave (
    output DB9_IN,
    input  DB9_TH,
    input  P_UP, P_DOWN, P_LEFT, P_RIGHT,
    input  P_A, P_B, P_C, P_START,
    input  P_MODE, P_X, P_Y, P_Z,
    input  PRESENT, SIX_BTN
  );

endinterface

// File: rtl/db9_sync.sv
// db9_sync: W-bit two-flop synchroniser with a configurable reset value.
// Ports: i_clk, i_rst (sync, high), i_d async in, o_q synchronised out.
module db9_sync #(
  parameter int           W       = 6,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/db9_pad_scan.sv
// db9_pad_scan: scans a Genesis-style DB9 pad by toggling TH, samples
// D0..D5 per phase into shadows, then updates all button outputs at once.
// Ports: CLK, RESET (sync high), CE, ENA, DB9_IN[5:0] (active-low pins),
// DB9_TH, P_UP..P_Z (active-high), PRESENT, SIX_BTN.
// Macro DB9_SIX_BTN_EN enables PH2..PH7 and the 6-button outputs.
module db9_pad_scan
  import db9_pkg::*;
#(
  parameter int SETTLE = DB9_SETTLE_DEF,
  parameter int IDLE   = DB9_IDLE_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       ENA,
  input  logic [5:0] DB9_IN,
  output logic       DB9_TH,
  output logic       P_UP,
  output logic       P_DOWN,
  output logic       P_LEFT,
  output logic       P_RIGHT,
  output logic       P_A,
  output logic       P_B,
  output logic       P_C,
  output logic       P_START,
  output logic       P_MODE,
  output logic       P_X,
  output logic       P_Y,
  output logic       P_Z,
  output logic       PRESENT,
  output logic       SIX_BTN
);

  logic [5:0]  w_sync;
  logic [5:0]  w_din;
  db9_state_e  r_state;
  db9_state_e  w_next;
  logic [7:0]  r_cnt;
  logic [15:0] r_idle;
  logic        r_th;
  logic        r_upd;
  logic        w_last;
  logic        w_idle_done;

  // base bits: 0 UP,1 DOWN,2 LEFT,3 RIGHT,4 A,5 B,6 C,7 START
  logic [7:0]  r_sh_base;
  logic [7:0]  r_base;
  logic        r_sh_pres;
  logic        r_pres;
`ifdef DB9_SIX_BTN_EN
  // ext bits: 0 Z,1 Y,2 X,3 MODE
  logic [3:0]  r_sh_ext;
  logic [3:0]  r_ext;
  logic        r_sh_six;
  logic        r_six;
`endif

  // Pins idle high (released), so reset the chain to all ones.
  db9_sync #(
    .W       (6),
    .RST_VAL (6'h3F)
  ) u_sync (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_d   (DB9_IN),
    .o_q   (w_sync)
  );

  assign w_din       = ~w_sync;
  assign w_last      = (r_cnt == 8'(SETTLE - 1));
  assign w_idle_done = (r_idle >= 16'(IDLE - 1));

  always_comb begin
    w_next = ST_IDLE;
    unique case (r_state)
      ST_IDLE: w_next = ST_PH0;
      ST_PH0:  w_next = ST_PH1;
`ifdef DB9_SIX_BTN_EN
      ST_PH1:  w_next = ST_PH2;
      ST_PH2:  w_next = ST_PH3;
      ST_PH3:  w_next = ST_PH4;
      ST_PH4:  w_next = ST_PH5;
      ST_PH5:  w_next = ST_PH6;
      ST_PH6:  w_next = ST_PH7;
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    r_upd <= 1'b0;
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_th      <= 1'b1;
      r_cnt     <= '0;
      r_idle    <= '0;
      r_sh_base <= '0;
      r_base    <= '0;
      r_sh_pres <= 1'b0;
      r_pres    <= 1'b0;
`ifdef DB9_SIX_BTN_EN
      r_sh_ext  <= '0;
      r_ext     <= '0;
      r_sh_six  <= 1'b0;
      r_six     <= 1'b0;
`endif
    end else begin
      // Publish the finished scan atomically.
      if (r_upd) begin
        r_pres <= r_sh_pres;
        r_base <= r_sh_pres ? r_sh_base : '0;
`ifdef DB9_SIX_BTN_EN
        r_six  <= r_sh_pres & r_sh_six;
        r_ext  <= (r_sh_pres & r_sh_six) ?
                  r_sh_ext : '0;
`endif
      end
      if (!ENA) begin
        r_state <= ST_IDLE;
        r_th    <= 1'b1;
        r_cnt   <= '0;
        r_idle  <= '0;
      end else if (CE) begin
        if (r_state == ST_IDLE) begin
          if (w_idle_done) begin
            r_state <= ST_PH0;
            r_th    <= 1'b1;
            r_cnt   <= '0;
            r_idle  <= '0;
          end else if (r_idle != '1) begin
            r_idle <= r_idle + 16'd1;
          end
        end else if (!w_last) begin
          r_cnt <= r_cnt + 8'd1;
        end else begin
          r_cnt   <= '0;
          r_state <= w_next;
          r_th    <= th_level(w_next);
          r_upd   <= (w_next == ST_IDLE);
          case (r_state)
            ST_PH0: begin
              r_sh_base[0] <= w_din[DB9_D0];
              r_sh_base[1] <= w_din[DB9_D1];
              r_sh_base[2] <= w_din[DB9_D2];
              r_sh_base[3] <= w_din[DB9_D3];
              r_sh_base[5] <= w_din[DB9_D4];
              r_sh_base[6] <= w_din[DB9_D5];
            end
            ST_PH1: begin
              r_sh_base[4] <= w_din[DB9_D4];
              r_sh_base[7] <= w_din[DB9_D5];
              // TH low grounds D2/D3 on any pad.
              r_sh_pres <= w_din[DB9_D2] &
                           w_din[DB9_D3];
            end
`ifdef DB9_SIX_BTN_EN
            ST_PH5: begin
              r_sh_six <= &w_din[DB9_D3:DB9_D0];
            end
            ST_PH6: begin
              r_sh_ext <= w_din[DB9_D3:DB9_D0];
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign DB9_TH  = r_th;
  assign P_UP    = r_base[0];
  assign P_DOWN  = r_base[1];
  assign P_LEFT  = r_base[2];
  assign P_RIGHT = r_base[3];
  assign P_A     = r_base[4];
  assign P_B     = r_base[5];
  assign P_C     = r_base[6];
  assign P_START = r_base[7];
  assign PRESENT = r_pres;
`ifdef DB9_SIX_BTN_EN
  assign P_Z     = r_ext[0];
  assign P_Y     = r_ext[1];
  assign P_X     = r_ext[2];
  assign P_MODE  = r_ext[3];
  assign SIX_BTN = r_six;
`else
  assign P_Z     = 1'b0;
  assign P_Y     = 1'b0;
  assign P_X     = 1'b0;
  assign P_MODE  = 1'b0;
  assign SIX_BTN = 1'b0;
`endif

endmodule
